// File: rtl/alu_mul_seq_if.sv
// Borrowed-ALU port of the multiply sequencer: the sequencer drives the
// operands/op and requests; the datapath mux grants and returns the result.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_req, alu_a, alu_b, alu_ctrl,
    input  alu_gnt, alu_result
  );

  modport slave (
    input  alu_req, alu_a, alu_b, alu_ctrl,
    output alu_gnt, alu_result
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 32x32 -> low-32 unsigned multiplier that owns no adder and
// borrows the shared ALU (ADD, SLL) one step at a time.
module alu_mul_seq #(
  parameter int       WIDTH      = 32,
  parameter bit [2:0] OP_ADD     = 3'b000,
  parameter bit [2:0] OP_SLL     = 3'b100,
  parameter bit       EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  alu_mul_seq_if.master    alu
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = (EARLY_EXIT && (op_b == '0)) ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        if (alu.alu_gnt) begin
          if (mplier_q[0]) begin
            acc_d = alu.alu_result;
          end
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (alu.alu_gnt) begin
          mcand_d  = alu.alu_result;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          // Stop after WIDTH steps, or early once no multiplier bits remain.
          if ((count_d == LAST_COUNT) || (EARLY_EXIT && (mplier_d == '0))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_DONE: begin
        product_d = acc_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu.alu_req  = 1'b0;
    alu.alu_a    = '0;
    alu.alu_b    = '0;
    alu.alu_ctrl = OP_ADD;
    case (state_q)
      S_ADD: begin
        alu.alu_req  = 1'b1;
        alu.alu_a    = acc_q;
        alu.alu_b    = mcand_q;
        alu.alu_ctrl = OP_ADD;
      end
      S_SHIFT: begin
        alu.alu_req  = 1'b1;
        alu.alu_a    = mcand_q;
        alu.alu_b    = WIDTH'(1);
        alu.alu_ctrl = OP_SLL;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
